// File: rtl/ripple_full_adder.sv
// rtl/ripple_full_adder.sv - registered BIT_WIDTH-bit ripple-carry adder with carry-out and signed overflow
//
// ripple_full_adder_cell : one full-adder bit
//   a, b, ci : operand bits and carry-in
//   s, co    : sum bit and carry-out
//
// ripple_full_adder : {cout, sum} = a + b + cin, registered once
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : qualifies a, b, cin this cycle
//   a, b      : BIT_WIDTH-bit operands
//   cin       : carry-in
//   sum       : registered low BIT_WIDTH bits of the result
//   cout      : registered carry-out
//   overflow  : registered two's-complement signed overflow
//   out_valid : one-cycle strobe marking a freshly loaded result

module ripple_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module ripple_full_adder #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 overflow,
  output logic                 out_valid
);

  // c[i] is the carry into bit i; c[BIT_WIDTH] is the adder carry-out.
  logic [BIT_WIDTH:0]   c;
  logic [BIT_WIDTH-1:0] s_comb;
  logic                 ovf_comb;

  assign c[0] = cin;

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
    ripple_full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_comb[i]),
      .co (c[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  // With BIT_WIDTH = 1 the carry into the sign bit is cin itself (c[0]).
  assign ovf_comb = c[BIT_WIDTH] ^ c[BIT_WIDTH-1];

  // Result registers only load on in_valid so idle (possibly X) inputs
  // never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s_comb;
        cout     <= c[BIT_WIDTH];
        overflow <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_ripple_full_adder.sv
// tb/tb_ripple_full_adder.sv - self-checking bench for ripple_full_adder against an arithmetic model

module tb_ripple_full_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         out_valid;

  int n_checks;
  int n_errors;

  // Reference state: what the registered outputs should currently show.
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;
  logic         exp_valid;

  ripple_full_adder #(.BIT_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sum"},       32'(sum),       32'(exp_sum));
    check({tag, ".cout"},      32'(cout),      32'(exp_cout));
    check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
  endtask

  task automatic model_reset();
    exp_sum   = '0;
    exp_cout  = 1'b0;
    exp_ovf   = 1'b0;
    exp_valid = 1'b0;
  endtask

  // Plain integer arithmetic: unsigned total gives {cout,sum}; the signed
  // interpretation of the operands decides overflow.
  task automatic model_update(input logic v, input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    int total;
    int sa;
    int sb;
    int stotal;
    exp_valid = v;
    if (v) begin
      total  = int'(ma) + int'(mb) + int'(mc);
      sa     = (int'(ma) >= (1 << (W-1))) ? int'(ma) - (1 << W) : int'(ma);
      sb     = (int'(mb) >= (1 << (W-1))) ? int'(mb) - (1 << W) : int'(mb);
      stotal = sa + sb + int'(mc);
      exp_sum  = total[W-1:0];
      exp_cout = total[W];
      exp_ovf  = (stotal > (1 << (W-1)) - 1) || (stotal < -(1 << (W-1)));
    end
  endtask

  // Called just after a rising edge: drive, wait one edge, check.
  task automatic step(input string tag, input logic v, input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sc);
    in_valid = v;
    a        = sa;
    b        = sb;
    cin      = sc;
    model_update(v, sa, sb, sc);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    model_reset();

    // Reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #2;
    check_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset_idle");

    // Directed cases.
    step("zero",      1'b1, 4'd0,  4'd0,  1'b0);
    step("all_ones",  1'b1, 4'd15, 4'd15, 1'b1);
    step("max_plus1", 1'b1, 4'd15, 4'd0,  1'b1);
    step("pos_ovf",   1'b1, 4'd7,  4'd1,  1'b0);
    step("neg_ovf",   1'b1, 4'd8,  4'd8,  1'b0);

    // Every {a, b, cin} back-to-back.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v9;
      v9 = 9'(i);
      step("exhaustive", 1'b1, v9[8:5], v9[4:1], v9[0]);
    end

    // Reset between edges mid-stream clears at once.
    step("pre_reset", 1'b1, 4'd9, 4'd9, 1'b1);
    in_valid = 1'b1;
    a        = 4'd3;
    b        = 4'd4;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("mid_reset_release");

    // Idle cycles with unknown inputs hold the last result.
    step("load", 1'b1, 4'd5, 4'd6, 1'b1);
    step("hold_x", 1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
    step("hold_x2", 1'b0, 4'bxxxx, 4'bxxxx, 1'bx);

    // Random stream with random valid gaps.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      step("random", 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
